vga_grid_renderer: RTL and testbench

Parametrised VGA timing generator and card-grid renderer for the memory game, successor to the fixed 4x4 display block. Generates 640x480-class sync from a pixel-rate enable, renders a GRID_COLS x GRID_ROWS board with 2-bit per-card state, inter-card gaps, a bordered (optionally blinking) cursor, and a frame-synchronous snapshot of game state to prevent tearing. Sits between the game controller and the board's VGA DAC pins.

---
 rtl/vga_grid_renderer_if.sv | 28 ++
 rtl/vga_grid_renderer.sv | 212 +++++++++++++++++++++
 tb/tb_vga_grid_renderer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_grid_renderer_if.sv
// rtl/vga_grid_renderer_if.sv - game-side pixel enable, board state and VGA output bundle
interface vga_grid_renderer_if #(
    parameter int GRID_COLS = 4,
    parameter int GRID_ROWS = 4
);
    localparam int N  = GRID_COLS * GRID_ROWS;
    localparam int IW = $clog2(N);

    logic            pix_en;
    logic [2*N-1:0]  card_states;
    logic [IW-1:0]   cursor_pos;
    logic            hsync;
    logic            vsync;
    logic [3:0]      red;
    logic [3:0]      green;
    logic [3:0]      blue;
    logic            frame_start;

    modport master (
        output pix_en, card_states, cursor_pos,
        input  hsync, vsync, red, green, blue, frame_start
    );

    modport slave (
        input  pix_en, card_states, cursor_pos,
        output hsync, vsync, red, green, blue, frame_start
    );
endinterface

// File: rtl/vga_grid_renderer.sv
// rtl/vga_grid_renderer.sv - VGA timing and card-grid renderer; define VGA_GRID_BLINK_EN for a blinking cursor
module vga_grid_renderer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int GRID_COLS  = 4,
    parameter int GRID_ROWS  = 4,
    parameter int CARD_LOG2  = 6,
    parameter int GAP        = 4,
    parameter int ORIGIN_X   = 64,
    parameter int ORIGIN_Y   = 0,
    parameter int BORDER     = 3,
    parameter int BLINK_LOG2 = 4
) (
    input  logic clk,
    input  logic reset,
    vga_grid_renderer_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int N       = GRID_COLS * GRID_ROWS;
    localparam int IW      = $clog2(N);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int RW      = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int BODY    = (1 << CARD_LOG2) - GAP;
    localparam int FW      = BLINK_LOG2 + 1;

    localparam logic [11:0] COL_BLANK  = 12'h000;
    localparam logic [11:0] COL_BG     = 12'h224;
    localparam logic [11:0] COL_CURSOR = 12'hF00;
    localparam logic [11:0] COL_DOWN   = 12'h555;
    localparam logic [11:0] COL_FLIP   = 12'hAAA;
    localparam logic [11:0] COL_MATCH  = 12'h0F0;
    localparam logic [11:0] COL_MISS   = 12'hF80;

    logic [HW-1:0]    h_count;
    logic [VW-1:0]    v_count;
    logic             h_last;
    logic             v_last;
    logic             wrap;
    logic [2*N-1:0]   shadow_states;
    logic [IW-1:0]    shadow_cursor;
    logic [FW-1:0]    frame_cnt;
    logic             cursor_vis;

    assign h_last          = (h_count == HW'(H_TOTAL - 1));
    assign v_last          = (v_count == VW'(V_TOTAL - 1));
    assign wrap            = bus.pix_en && h_last && v_last;
    assign bus.frame_start = wrap;

    // Raster counters: h steps every pixel, v steps when h wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (bus.pix_en) begin
            if (h_last) begin
                h_count <= '0;
                v_count <= v_last ? '0 : v_count + VW'(1);
            end else begin
                h_count <= h_count + HW'(1);
            end
        end
    end

    // Game state is sampled only at the frame boundary so a frame never tears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_states <= '0;
            shadow_cursor <= '0;
            frame_cnt     <= '0;
        end else if (wrap) begin
            shadow_states <= bus.card_states;
            shadow_cursor <= bus.cursor_pos;
            frame_cnt     <= frame_cnt + FW'(1);
        end
    end

`ifdef VGA_GRID_BLINK_EN
    assign cursor_vis = ~frame_cnt[BLINK_LOG2];
`else
    logic unused_frame_cnt;
    assign unused_frame_cnt = ^frame_cnt;
    assign cursor_vis       = 1'b1;
`endif

    int                   h_i;
    int                   v_i;
    int                   rx;
    int                   ry;
    logic                 blank_c;
    logic                 hs_c;
    logic                 vs_c;
    logic                 in_grid;
    logic                 body_c;
    logic [CW-1:0]        col_c;
    logic [RW-1:0]        row_c;
    logic [CARD_LOG2-1:0] lx_c;
    logic [CARD_LOG2-1:0] ly_c;

    // Stage 1 decode: blanking, raw sync and grid cell / local offset of the current pixel
    always_comb begin
        h_i     = int'(h_count);
        v_i     = int'(v_count);
        rx      = h_i - ORIGIN_X;
        ry      = v_i - ORIGIN_Y;
        blank_c = (h_i >= H_ACTIVE) || (v_i >= V_ACTIVE);
        hs_c    = (h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC);
        vs_c    = (v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC);
        in_grid = (rx >= 0) && (ry >= 0) &&
                  ((rx >>> CARD_LOG2) < GRID_COLS) && ((ry >>> CARD_LOG2) < GRID_ROWS);
        col_c   = CW'(rx >>> CARD_LOG2);
        row_c   = RW'(ry >>> CARD_LOG2);
        lx_c    = rx[CARD_LOG2-1:0];
        ly_c    = ry[CARD_LOG2-1:0];
        body_c  = in_grid && (int'(lx_c) < BODY) && (int'(ly_c) < BODY);
    end

    logic                 s1_blank;
    logic                 s1_hs;
    logic                 s1_vs;
    logic                 s1_body;
    logic [CW-1:0]        s1_col;
    logic [RW-1:0]        s1_row;
    logic [CARD_LOG2-1:0] s1_lx;
    logic [CARD_LOG2-1:0] s1_ly;

    // Stage 1 register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_blank <= 1'b1;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_body  <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_lx    <= '0;
            s1_ly    <= '0;
        end else if (bus.pix_en) begin
            s1_blank <= blank_c;
            s1_hs    <= hs_c;
            s1_vs    <= vs_c;
            s1_body  <= body_c;
            s1_col   <= col_c;
            s1_row   <= row_c;
            s1_lx    <= lx_c;
            s1_ly    <= ly_c;
        end
    end

    logic [IW-1:0] idx;
    logic [1:0]    st;
    logic          edge_px;
    logic          cursor_hit;
    logic [11:0]   rgb_c;

    // Stage 2 lookup: card state, cursor border and colour priority
    always_comb begin
        idx        = IW'(s1_row) * IW'(GRID_COLS) + IW'(s1_col);
        st         = 2'(shadow_states >> {idx, 1'b0});
        edge_px    = (int'(s1_lx) < BORDER) || (int'(s1_ly) < BORDER) ||
                     (int'(s1_lx) >= BODY - BORDER) || (int'(s1_ly) >= BODY - BORDER);
        // An out-of-range cursor never equals a valid card index, so it draws nothing
        cursor_hit = cursor_vis && edge_px && (idx == shadow_cursor);
        rgb_c      = COL_BLANK;
        if (s1_blank) begin
            rgb_c = COL_BLANK;
        end else if (!s1_body) begin
            rgb_c = COL_BG;
        end else if (cursor_hit) begin
            rgb_c = COL_CURSOR;
        end else begin
            case (st)
                2'b00:   rgb_c = COL_DOWN;
                2'b01:   rgb_c = COL_FLIP;
                2'b10:   rgb_c = COL_MATCH;
                default: rgb_c = COL_MISS;
            endcase
        end
    end

    logic [11:0] rgb_q;
    logic        hs_q;
    logic        vs_q;

    // Stage 2 register: colour and sync leave together so they stay aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= COL_BLANK;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
        end else if (bus.pix_en) begin
            rgb_q <= rgb_c;
            hs_q  <= s1_hs ? SYNC_POL : ~SYNC_POL;
            vs_q  <= s1_vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign bus.red   = rgb_q[11:8];
    assign bus.green = rgb_q[7:4];
    assign bus.blue  = rgb_q[3:0];
    assign bus.hsync = hs_q;
    assign bus.vsync = vs_q;
endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb/tb_vga_grid_renderer.sv - directed self-checking bench for vga_grid_renderer on a reduced raster
module tb_vga_grid_renderer;
    localparam int HT = 64;
    localparam int VT = 44;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests = 0;
    int          fails = 0;
    int          cyc;
    logic [11:0] rgb;

    vga_grid_renderer_if #(.GRID_COLS(3), .GRID_ROWS(4)) bus();

    vga_grid_renderer #(
        .H_ACTIVE(48), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(36), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_POL(1'b0),
        .GRID_COLS(3), .GRID_ROWS(4), .CARD_LOG2(3), .GAP(2),
        .ORIGIN_X(8), .ORIGIN_Y(2), .BORDER(1), .BLINK_LOG2(1)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else if (bus.pix_en) cyc <= cyc + 1;
    end

    assign rgb = {bus.red, bus.green, bus.blue};

    task automatic goto(input int t);
        int guard = 0;
        while (cyc < t && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (cyc != t) begin
            $display("FAIL goto: cycle %0d required %0d", cyc, t);
            fails++;
        end
    endtask

    task automatic do_reset(input logic [23:0] st, input logic [3:0] cur);
        @(negedge clk);
        rst = 1'b1;
        bus.pix_en = 1'b1;
        bus.card_states = st;
        bus.cursor_pos = cur;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (rgb !== 12'h000) begin $display("FAIL reset_rgb: got %h expected 000", rgb); fails++; end
        tests++;
        if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
            $display("FAIL reset_sync: got h=%b v=%b expected 1 1", bus.hsync, bus.vsync); fails++;
        end
        tests++;
        if (bus.frame_start !== 1'b0) begin $display("FAIL reset_fs: got %b expected 0", bus.frame_start); fails++; end
        tests++;
        if (dut.frame_cnt !== 2'd0 || dut.h_count !== 6'd0 || dut.v_count !== 6'd0) begin
            $display("FAIL reset_cnt: got f=%0d h=%0d v=%0d expected 0 0 0", dut.frame_cnt, dut.h_count, dut.v_count); fails++;
        end
    endtask

    task automatic test_sync();
        int lows = 0;
        int hc[4] = '{53, 54, 59, 60};
        logic he[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int vc[4] = '{2433, 2434, 2561, 2562};
        logic ve[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset(24'h0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            goto(hc[i]);
            tests++;
            if (bus.hsync !== he[i]) begin $display("FAIL hsync@%0d: got %b expected %b", hc[i], bus.hsync, he[i]); fails++; end
        end
        for (int c = 66; c < 130; c++) begin
            goto(c);
            if (bus.hsync === 1'b0) lows++;
        end
        tests++;
        if (lows != 6) begin $display("FAIL hsync_width: got %0d expected 6", lows); fails++; end
        for (int i = 0; i < 4; i++) begin
            goto(vc[i]);
            tests++;
            if (bus.vsync !== ve[i]) begin $display("FAIL vsync@%0d: got %b expected %b", vc[i], bus.vsync, ve[i]); fails++; end
        end
        goto(FR - 2);
        tests++;
        if (bus.frame_start !== 1'b0) begin $display("FAIL fs_early: got %b expected 0", bus.frame_start); fails++; end
        goto(FR - 1);
        tests++;
        if (bus.frame_start !== 1'b1) begin $display("FAIL fs_first: got %b expected 1", bus.frame_start); fails++; end
        goto(FR);
        tests++;
        if (bus.frame_start !== 1'b0 || dut.frame_cnt !== 2'd1) begin
            $display("FAIL fs_after: got fs=%b cnt=%0d expected 0 1", bus.frame_start, dut.frame_cnt); fails++;
        end
        goto(2 * FR - 1);
        tests++;
        if (bus.frame_start !== 1'b1) begin $display("FAIL fs_period: got %b expected 1", bus.frame_start); fails++; end
    endtask

    task automatic test_default_frame();
        int h0[11] = '{12, 8, 4, 12, 14, 20, 40, 50, 13, 12, 12};
        int v0[11] = '{1, 2, 6, 6, 6, 6, 6, 6, 7, 34, 37};
        logic [11:0] e0[11] = '{12'h224, 12'hF00, 12'h224, 12'h555, 12'h224, 12'h555,
                                12'h224, 12'h000, 12'hF00, 12'h224, 12'h000};
        int h1[6] = '{8, 12, 16, 19, 22, 21};
        int v1[6] = '{2, 6, 10, 13, 13, 15};
        logic [11:0] e1[6] = '{12'hAAA, 12'hAAA, 12'hF00, 12'hAAA, 12'h224, 12'hF00};
        do_reset(24'h555555, 4'd4);
        for (int i = 0; i < 11; i++) begin
            goto(v0[i] * HT + h0[i] + 2);
            tests++;
            if (rgb !== e0[i]) begin $display("FAIL frame0_px(%0d,%0d): got %h expected %h", h0[i], v0[i], rgb, e0[i]); fails++; end
        end
        for (int i = 0; i < 6; i++) begin
            goto(FR + v1[i] * HT + h1[i] + 2);
            tests++;
            if (rgb !== e1[i]) begin $display("FAIL frame1_px(%0d,%0d): got %h expected %h", h1[i], v1[i], rgb, e1[i]); fails++; end
        end
    endtask

    task automatic test_states();
        int h[5] = '{8, 11, 27, 19, 27};
        int v[5] = '{2, 13, 13, 29, 29};
        logic [11:0] e[5] = '{12'hF00, 12'h555, 12'h0F0, 12'hF80, 12'h555};
        do_reset((24'h2 << 10) | (24'h3 << 20), 4'd0);
        for (int i = 0; i < 5; i++) begin
            goto(FR + v[i] * HT + h[i] + 2);
            tests++;
            if (rgb !== e[i]) begin $display("FAIL state_px(%0d,%0d): got %h expected %h", h[i], v[i], rgb, e[i]); fails++; end
        end
    endtask

    task automatic test_mid_frame_change();
        int h1[2] = '{24, 11};
        int v1[2] = '{26, 29};
        logic [11:0] e1[2] = '{12'hF00, 12'h0F0};
        int h2[3] = '{8, 24, 11};
        int v2[3] = '{26, 26, 29};
        logic [11:0] e2[3] = '{12'hF00, 12'hAAA, 12'hF80};
        int h3[2] = '{8, 11};
        int v3[2] = '{26, 29};
        logic [11:0] e3[2] = '{12'hAAA, 12'hAAA};
        do_reset(24'h2 << 18, 4'd11);
        goto(FR + 20 * HT);
        bus.card_states = (24'h3 << 18) | (24'h1 << 22);
        bus.cursor_pos = 4'd9;
        for (int i = 0; i < 2; i++) begin
            goto(FR + v1[i] * HT + h1[i] + 2);
            tests++;
            if (rgb !== e1[i]) begin $display("FAIL old_state_px(%0d,%0d): got %h expected %h", h1[i], v1[i], rgb, e1[i]); fails++; end
        end
        for (int i = 0; i < 3; i++) begin
            goto(2 * FR + v2[i] * HT + h2[i] + 2);
            tests++;
            if (rgb !== e2[i]) begin $display("FAIL new_state_px(%0d,%0d): got %h expected %h", h2[i], v2[i], rgb, e2[i]); fails++; end
        end
        goto(3 * FR - 1);
        tests++;
        if (bus.frame_start !== 1'b1) begin $display("FAIL capture_fs: got %b expected 1", bus.frame_start); fails++; end
        bus.card_states = 24'h1 << 18;
        bus.cursor_pos = 4'd15;
        goto(3 * FR);
        bus.card_states = 24'h2 << 18;
        bus.cursor_pos = 4'd9;
        for (int i = 0; i < 2; i++) begin
            goto(3 * FR + v3[i] * HT + h3[i] + 2);
            tests++;
            if (rgb !== e3[i]) begin $display("FAIL same_cycle_px(%0d,%0d): got %h expected %h", h3[i], v3[i], rgb, e3[i]); fails++; end
        end
    endtask

    task automatic test_cursor_range();
        int red1 = 0;
        int red2 = 0;
        do_reset(24'h0, 4'd11);
        for (int c = FR + 2; c < 2 * FR + 2; c++) begin
            goto(c);
            if (c == FR + 100) bus.cursor_pos = 4'd12;
            if (rgb === 12'hF00) red1++;
        end
        tests++;
        if (red1 != 20) begin $display("FAIL cursor_border_count: got %0d expected 20", red1); fails++; end
        for (int c = 2 * FR + 2; c < 3 * FR + 2; c++) begin
            goto(c);
            if (rgb === 12'hF00) red2++;
        end
        tests++;
        if (red2 != 0) begin $display("FAIL cursor_out_of_range: got %0d red pixels expected 0", red2); fails++; end
    endtask

    task automatic test_hold();
        do_reset(24'h0, 4'd0);
        goto(6 * HT + 13 + 2);
        tests++;
        if (rgb !== 12'hF00) begin $display("FAIL hold_pre: got %h expected F00", rgb); fails++; end
        bus.pix_en = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (rgb !== 12'hF00 || dut.h_count !== 6'd15 || bus.hsync !== 1'b1) begin
            $display("FAIL hold: got rgb=%h h=%0d hs=%b expected F00 15 1", rgb, dut.h_count, bus.hsync); fails++;
        end
        bus.pix_en = 1'b1;
        @(negedge clk);
        tests++;
        if (rgb !== 12'h224) begin $display("FAIL hold_resume: got %h expected 224", rgb); fails++; end
    endtask

    task automatic test_reset_mid_frame();
        do_reset(24'h0, 4'd0);
        goto(FR + 30 * HT + 9 + 2);
        tests++;
        if (rgb !== 12'h555 || dut.frame_cnt !== 2'd1) begin
            $display("FAIL mid_pre: got rgb=%h cnt=%0d expected 555 1", rgb, dut.frame_cnt); fails++;
        end
        rst = 1'b1;
        #1;
        tests++;
        if (rgb !== 12'h000 || bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
            $display("FAIL mid_reset_out: got rgb=%h hs=%b vs=%b expected 000 1 1", rgb, bus.hsync, bus.vsync); fails++;
        end
        tests++;
        if (dut.h_count !== 6'd0 || dut.v_count !== 6'd0 || dut.frame_cnt !== 2'd0) begin
            $display("FAIL mid_reset_cnt: got h=%0d v=%0d f=%0d expected 0 0 0", dut.h_count, dut.v_count, dut.frame_cnt); fails++;
        end
        @(negedge clk);
        rst = 1'b0;
        goto(FR - 2);
        tests++;
        if (bus.frame_start !== 1'b0) begin $display("FAIL mid_fs_early: got %b expected 0", bus.frame_start); fails++; end
        goto(FR - 1);
        tests++;
        if (bus.frame_start !== 1'b1) begin $display("FAIL mid_fs_first: got %b expected 1", bus.frame_start); fails++; end
    endtask

    task automatic test_blink();
`ifdef VGA_GRID_BLINK_EN
        logic [11:0] e[5] = '{12'hF00, 12'hF00, 12'h555, 12'h555, 12'hF00};
`else
        logic [11:0] e[5] = '{12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00};
`endif
        do_reset(24'h0, 4'd0);
        for (int f = 0; f < 5; f++) begin
            goto(f * FR + 2 * HT + 8 + 2);
            tests++;
            if (rgb !== e[f]) begin $display("FAIL blink_frame%0d: got %h expected %h", f, rgb, e[f]); fails++; end
        end
    endtask

    initial begin
        bus.pix_en = 1'b0;
        bus.card_states = 24'h0;
        bus.cursor_pos = 4'd0;
        test_reset();
        test_sync();
        test_default_frame();
        test_states();
        test_mid_frame_change();
        test_cursor_range();
        test_hold();
        test_reset_mid_frame();
        test_blink();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
